// File: rtl/apb_req_queue.sv
// Purpose : queues host read/write requests and plays them one at a time onto a
//           simple APB-style bridge (dsel/trnsfr/wr/address/data_in, done/data_out),
//           with a WAIT-cycle timeout that turns a stuck transfer into an error response.
// Latency : request accepted into an empty queue while idle is in SETUP two cycles later;
//           response appears the cycle after done (or after TIMEOUT WAIT cycles).
// Backpressure: req_ready drops while the FIFO holds DEPTH entries; a pending response
//           holds in RESP (and blocks the next SETUP) until resp_ready.
// Ports   : clk, rst (sync, active-high)
//           host req  : req_valid/req_ready, req_wr, req_addr, req_wdata
//           host resp : resp_valid/resp_ready, resp_rdata, resp_err
//           bridge    : dsel, trnsfr, wr, address, data_in (out); data_out, done (in)
module apb_req_queue #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dsel,
  output logic              trnsfr,
  output logic              wr,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // request FIFO storage (not reset: contents are only read when r_count says valid)
  logic              r_fifo_wr   [DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [TMR_W-1:0]  r_wait_cnt;

  logic              r_dsel;
  logic              r_trnsfr;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_push;
  logic              w_pop;
  logic              w_timeout;

  // Ready comes from the registered count only, so a same-cycle pop on a full
  // queue cannot reopen it; rst masks it so nothing is accepted during reset.
  assign req_ready = !rst && (r_count < FULL_CNT);
  assign w_push    = req_valid && req_ready;
  assign w_timeout = (r_wait_cnt == TMR_LAST);

  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign dsel       = r_dsel;
  assign trnsfr     = r_trnsfr;
  assign wr         = r_wr;
  assign address    = r_addr;
  assign data_in    = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_WAIT;
      // done has priority over the timeout; both end the transfer
      S_WAIT:  if (done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wr[r_wptr]   <= req_wr;
      r_fifo_addr[r_wptr] <= req_addr;
      r_fifo_data[r_wptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_wait_cnt   <= '0;
      r_dsel       <= 1'b0;
      r_trnsfr     <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // counts WAIT cycles from 0; cleared whenever the next cycle is not WAIT
      if (r_state == S_WAIT && w_state_nxt == S_WAIT) r_wait_cnt <= r_wait_cnt + TMR_W'(1);
      else                                           r_wait_cnt <= '0;

      // bridge strobes are decoded from the next state so they are plain flops
      r_dsel   <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_WAIT);
      r_trnsfr <= (w_state_nxt == S_SETUP);

      if (w_pop) begin
        r_wr    <= r_fifo_wr[r_rptr];
        r_addr  <= r_fifo_addr[r_rptr];
        r_wdata <= r_fifo_data[r_rptr];
      end

      if (r_state == S_WAIT) begin
        if (done) begin
          r_resp_rdata <= r_wr ? '0 : data_out;
          r_resp_err   <= 1'b0;
        end else if (w_timeout) begin
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b1;
        end
      end else if (r_state == S_RESP && resp_ready) begin
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b0;
      end
    end
  end

endmodule
